// File: rtl/edm_pkg.sv
// Shared types and constants for the EDM discharge-pulse generator.
package edm_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    PG_IDLE = 2'd0,
    PG_ON   = 2'd1,
    PG_OFF  = 2'd2
  } pg_state_t;

  localparam logic WAVE_CONT   = 1'b0;
  localparam logic WAVE_SINGLE = 1'b1;

endpackage

// File: rtl/edm_pulse_gen.sv
// Ton/Toff gate pulse train for the EDM power stage, driven by the SPI command block.
// Parameters are sampled only at period boundaries, so a pulse is never truncated by a live update.
module edm_pulse_gen
  import edm_pkg::*;
#(
  parameter int CNT_W = edm_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             machine_start,
  input  logic             machine_stop,
  input  logic [CNT_W-1:0] Ton_data,
  input  logic [CNT_W-1:0] Toff_data,
  input  logic [15:0]      Ip_data,
  input  logic [15:0]      waveform_data,
  output logic             gate_out,
  output logic [15:0]      ip_level,
  output logic             busy,
  output logic             pulse_done,
  output logic [15:0]      pulse_cnt,
  output logic             param_err,
  output logic [1:0]       dbg_state
);

  // Handshake: machine_start/machine_stop are single-cycle strobes with no ready;
  // a start is consumed only in IDLE, and stop always wins when both are high.

  pg_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_toff;
  logic             r_mode;
  logic [15:0]      r_ip;
  logic             r_gate;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_pulse_cnt;
  logic             r_err;

  logic             w_params_ok;
  logic             w_cnt_zero;
  logic [15:0]      w_pcnt_next;
  logic             w_unused_bits;

  assign w_params_ok   = (Ton_data != '0) && (Toff_data != '0);
  assign w_cnt_zero    = (r_cnt == '0);
  assign w_pcnt_next   = (r_pulse_cnt == 16'hFFFF) ? r_pulse_cnt : r_pulse_cnt + 16'd1;
  assign w_unused_bits = ^waveform_data[15:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= PG_IDLE;
      r_cnt       <= '0;
      r_toff      <= '0;
      r_mode      <= WAVE_CONT;
      r_ip        <= '0;
      r_gate      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pulse_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        PG_IDLE: begin
          if (machine_start && !machine_stop) begin
            if (w_params_ok) begin
              r_toff      <= Toff_data;
              r_ip        <= Ip_data;
              r_mode      <= waveform_data[0];
              r_pulse_cnt <= '0;
              r_err       <= 1'b0;
              r_cnt       <= Ton_data - 1'b1;
              r_gate      <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= PG_ON;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        PG_ON: begin
          if (machine_stop) begin
            r_cnt   <= '0;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= PG_IDLE;
          end else if (w_cnt_zero) begin
            r_cnt   <= r_toff - 1'b1;
            r_gate  <= 1'b0;
            r_state <= PG_OFF;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        PG_OFF: begin
          if (machine_stop) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= PG_IDLE;
          end else if (w_cnt_zero) begin
            r_done      <= 1'b1;
            r_pulse_cnt <= w_pcnt_next;
            if (r_mode == WAVE_SINGLE) begin
              r_busy  <= 1'b0;
              r_state <= PG_IDLE;
            end else if (w_params_ok) begin
              // Back-to-back period: re-sample live parameters here and only here.
              r_toff  <= Toff_data;
              r_ip    <= Ip_data;
              r_mode  <= waveform_data[0];
              r_cnt   <= Ton_data - 1'b1;
              r_gate  <= 1'b1;
              r_state <= PG_ON;
            end else begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= PG_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_gate  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= PG_IDLE;
        end
      endcase
    end
  end

  assign gate_out   = r_gate;
  assign ip_level   = r_ip;
  assign busy       = r_busy;
  assign pulse_done = r_done;
  assign pulse_cnt  = r_pulse_cnt;
  assign param_err  = r_err;
  assign dbg_state  = r_state;

endmodule

// File: doc/edm_pulse_gen.md
# edm_pulse_gen

Discharge-pulse generator sitting directly downstream of `spi_slave_cmd`. Consumes the command outputs (`machine_start`, `machine_stop`, `Ton_data`, `Toff_data`, `Ip_data`, `waveform_data`) and drives the power-stage gate with a Ton/Toff pulse train in `sys_clk` cycles. Returns a 16-bit pulse count that the top level routes onto `feedback_data`.

## Interface
- `CNT_W`, 16: width of the Ton/Toff timing fields and the internal down-counter.
- `clk`  in  1: system clock, 100 MHz (`sys_clk`).
- `rst_n`  in  1: reset, synchronous, active-low.
- `machine_start`  in  1: one-cycle start strobe.
- `machine_stop`  in  1: one-cycle stop strobe.
- `Ton_data`  in  16: gate-high time in clk cycles. 0 is invalid.
- `Toff_data`  in  16: gate-low time in clk cycles. 0 is invalid.
- `Ip_data`  in  16: peak-current setpoint. Latched and passed through.
- `waveform_data`  in  16: bit0 = 0 continuous, 1 single-shot. Bits 15:1 reserved and ignored.
- `gate_out`  out  1: power-stage gate drive. High during ON.
- `ip_level`  out  16: `Ip_data` latched at the last parameter load.
- `busy`  out  1: high in any state other than IDLE.
- `pulse_done`  out  1: one-cycle strobe at the end of each completed Ton+Toff period.
- `pulse_cnt`  out  16: completed periods since the last accepted start. Saturates at 16'hFFFF.
- `param_err`  out  1: sticky. Set when a start is rejected; cleared by the next accepted start.

## Operation
- States: IDLE, ON, OFF.
- **IDLE**
  - If `machine_start` is high and both Ton_data and Toff_data are nonzero, the start is accepted.
  - On an accepted start, latch Ton, Toff, Ip and mode; clear `pulse_cnt` and `param_err`; load counter = Ton−1; go to ON.
  - If `machine_start` is high and either Ton_data or Toff_data is 0, set `param_err` and stay in IDLE.
- **ON**
  - `gate_out` = 1 and the counter decrements each cycle.
  - At counter = 0: load counter = Toff−1 and go to OFF.
- **OFF**
  - `gate_out` = 0 and the counter decrements each cycle.
  - At counter = 0:
    - pulse `pulse_done` and increment `pulse_cnt` (saturating);
    - if mode is single-shot, go to IDLE;
    - otherwise re-sample Ton_data, Toff_data, Ip_data and waveform_data, load counter = new Ton−1, and go to ON.
- Live parameter updates take effect only at a period boundary, so there is never a truncated pulse.
  - If a re-sampled Ton or Toff is 0, set `param_err` and go to IDLE.
- **Stop**
  - `machine_stop` in ON or OFF: next state is IDLE and `gate_out` = 0 on the next edge.
  - `pulse_cnt` holds its value; no `pulse_done` is generated for the aborted period.
- **Start while busy:** ignored; latched parameters are unchanged.
- **Start and stop in the same cycle:** stop wins. In IDLE the block stays IDLE with no parameter latch and no `param_err` change.
- **Reserved bits:** `waveform_data[15:1]` never affects behaviour.

## Timing
- Reset values: state IDLE, counter 0, `gate_out` 0, `busy` 0, `pulse_done` 0, `pulse_cnt` 0, `param_err` 0, `ip_level` 0.
- All outputs are registered.
- Start sampled at edge t:
  - `gate_out` and `busy` rise at t+1;
  - `gate_out` is high for exactly Ton cycles, then low for exactly Toff cycles.
- Period is Ton+Toff cycles with no gap between consecutive periods.
- `pulse_done` is high during the last OFF cycle's following edge, i.e. coincident with `gate_out` rising for the next period in continuous mode.
- `pulse_cnt` updates on the same edge that asserts `pulse_done`.
- Single-shot: `busy` falls on the same edge that asserts `pulse_done`.
- Ton = 1 or Toff = 1 gives a one-cycle phase; this must work.
- Stop sampled at edge s: `gate_out` = 0 and `busy` = 0 from s+1.
- Reset asserted mid-pulse: `gate_out` = 0 from the next edge.

## Structure
- Package `edm_pkg` holds:
  - the state enum `pg_state_t` (IDLE/ON/OFF);
  - `WAVE_CONT` = 1'b0 and `WAVE_SINGLE` = 1'b1;
  - the default `CNT_W`.
- Single module; no sub-module needed. The down-counter and FSM share one always block per register group.
- Top-level integration: `feedback_data <= pulse_cnt` registered in `fpga_slave`.

## Test plan
1. Ton = 5, Toff = 3, continuous, start -> `gate_out` shows a 5-high/3-low pattern repeating; `pulse_done` every 8 cycles; `pulse_cnt` 1, 2, 3…
2. Ton = 1, Toff = 1, single-shot -> `gate_out` high for 1 cycle; `busy` falls 2 cycles after rising; `pulse_cnt` = 1.
3. Ton = 0, Toff = 10, start -> stays IDLE; `param_err` = 1; a following start with Ton = 4, Toff = 4 clears `param_err` and runs.
4. Running Ton = 10, Toff = 10; change Ton to 2 mid-ON -> current pulse stays 10 cycles; next pulse is 2 cycles.
5. Stop on cycle 3 of ON (Ton = 8) -> `gate_out` = 0 next cycle; `busy` = 0; `pulse_cnt` unchanged; start and stop together in IDLE -> no change.
6. Preload `pulse_cnt` = 16'hFFFE with Ton = Toff = 1, run for 4 periods -> `pulse_cnt` saturates at 16'hFFFF; `rst_n` low mid-ON -> all outputs at reset values next edge.
